// File: rtl/mw_writeback_stage_if.sv
// Bus between the X/M stage, the M/W latch and the regfile/bypass consumers.
// The slave modport is the writeback stage; the master modport is whatever drives it.
interface mw_writeback_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] xm_ir;
  logic [31:0] xm_o;
  logic [4:0]  xm_rd;
  logic        xm_exc;
  logic [31:0] dmem_q;
  logic        exc_ack;

  logic [31:0] mw_ir;
  logic        rf_we;
  logic [4:0]  rf_wr_reg;
  logic [31:0] rf_wr_data;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
  logic        exc_pulse;
  logic        exc_pending;
  logic [2:0]  exc_last;

  modport master (
    output stall, flush, xm_ir, xm_o, xm_rd, xm_exc, dmem_q, exc_ack,
    input  mw_ir, rf_we, rf_wr_reg, rf_wr_data, byp_valid, byp_rd, byp_data,
           exc_pulse, exc_pending, exc_last
  );

  modport slave (
    input  stall, flush, xm_ir, xm_o, xm_rd, xm_exc, dmem_q, exc_ack,
    output mw_ir, rf_we, rf_wr_reg, rf_wr_data, byp_valid, byp_rd, byp_data,
           exc_pulse, exc_pending, exc_last
  );
endinterface

// File: rtl/mw_writeback_stage.sv
// M/W pipeline latch, writeback decode, bypass source and sticky exception status.
// Define MW_EXC_COUNT_EN to add saturating per-code exception counters on exc_cnt.
module mw_writeback_stage #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  mw_writeback_stage_if.slave    bus
`ifdef MW_EXC_COUNT_EN
  ,
  output logic [5*CNT_W-1:0]     exc_cnt
`endif
);

  localparam logic [4:0] OpAlu  = 5'b00000;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpLw   = 5'b01000;
  localparam logic [4:0] OpJal  = 5'b00011;
  localparam logic [4:0] OpSetx = 5'b10101;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;

  localparam logic [4:0] RegExc = 5'd30;

  logic [31:0] ir_q, ir_d;
  logic [31:0] o_q, o_d;
  logic [4:0]  rd_q, rd_d;
  logic        exc_q, exc_d;
  logic [31:0] q_q, q_d;
  logic        held_q, held_d;
  logic        pending_q, pending_d;
  logic [2:0]  last_q, last_d;

  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic        is_writer;
  logic        exc_kind;
  logic        code_ok;
  logic        we;
  logic [31:0] wr_data;
  logic        pulse;

  always_comb begin
    opcode    = ir_q[31:27];
    aluop     = ir_q[6:2];
    is_writer = (opcode == OpAlu) || (opcode == OpAddi) || (opcode == OpLw) ||
                (opcode == OpJal) || (opcode == OpSetx);
    exc_kind  = ((opcode == OpAlu) &&
                 ((aluop == AluAdd) || (aluop == AluSub) ||
                  (aluop == AluMul) || (aluop == AluDiv))) ||
                (opcode == OpAddi);
    code_ok   = (o_q >= 32'd1) && (o_q <= 32'd5);
    we        = is_writer && (rd_q != 5'd0);
    wr_data   = (opcode == OpLw) ? q_q : o_q;
    // A latch held by stall still carries the same instruction; pulse only on its first cycle.
    pulse     = exc_q && exc_kind && (rd_q == RegExc) && code_ok && !held_q;
  end

  always_comb begin
    ir_d      = ir_q;
    o_d       = o_q;
    rd_d      = rd_q;
    exc_d     = exc_q;
    q_d       = q_q;
    held_d    = 1'b0;
    pending_d = pending_q;
    last_d    = last_q;

    if (bus.flush) begin
      ir_d  = 32'd0;
      o_d   = 32'd0;
      rd_d  = 5'd0;
      exc_d = 1'b0;
      q_d   = 32'd0;
    end else if (bus.stall) begin
      held_d = 1'b1;
    end else begin
      ir_d  = bus.xm_ir;
      o_d   = bus.xm_o;
      rd_d  = bus.xm_rd;
      exc_d = bus.xm_exc;
      q_d   = bus.dmem_q;
    end

    // A new exception wins over a simultaneous acknowledge.
    if (pulse) begin
      pending_d = 1'b1;
      last_d    = o_q[2:0];
    end else if (bus.exc_ack) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q      <= 32'd0;
      o_q       <= 32'd0;
      rd_q      <= 5'd0;
      exc_q     <= 1'b0;
      q_q       <= 32'd0;
      held_q    <= 1'b0;
      pending_q <= 1'b0;
      last_q    <= 3'd0;
    end else begin
      ir_q      <= ir_d;
      o_q       <= o_d;
      rd_q      <= rd_d;
      exc_q     <= exc_d;
      q_q       <= q_d;
      held_q    <= held_d;
      pending_q <= pending_d;
      last_q    <= last_d;
    end
  end

`ifdef MW_EXC_COUNT_EN
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (pulse && (o_q[2:0] == 3'(i + 1)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign exc_cnt = cnt_q;
`endif

  assign bus.mw_ir       = ir_q;
  assign bus.rf_we       = we;
  assign bus.rf_wr_reg   = rd_q;
  assign bus.rf_wr_data  = wr_data;
  assign bus.byp_valid   = we;
  assign bus.byp_rd      = rd_q;
  assign bus.byp_data    = wr_data;
  assign bus.exc_pulse   = pulse;
  assign bus.exc_pending = pending_q;
  assign bus.exc_last    = last_q;

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Directed bench for mw_writeback_stage: latch, writeback select, exception status and
// (with MW_EXC_COUNT_EN) counter saturation at CNT_W=2.
module tb_mw_writeback_stage;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  mw_writeback_stage_if wb ();

`ifdef MW_EXC_COUNT_EN
  logic [9:0] exc_cnt;
  mw_writeback_stage #(.CNT_W(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (wb.slave),
    .exc_cnt (exc_cnt)
  );
`else
  mw_writeback_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (wb.slave)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] aluop);
    return {op, 20'd0, aluop, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] o, input logic [4:0] rd,
                       input logic exc, input logic [31:0] q);
    wb.xm_ir  = ir;
    wb.xm_o   = o;
    wb.xm_rd  = rd;
    wb.xm_exc = exc;
    wb.dmem_q = q;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n    = 1'b0;
    wb.stall   = 1'b0;
    wb.flush   = 1'b0;
    wb.exc_ack = 1'b0;
    drive(32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    chk("rst_mw_ir", wb.mw_ir, 32'd0);
    chk("rst_rf_we", {31'd0, wb.rf_we}, 32'd0);
    chk("rst_wr_data", wb.rf_wr_data, 32'd0);
    chk("rst_pending", {31'd0, wb.exc_pending}, 32'd0);
    chk("rst_last", {29'd0, wb.exc_last}, 32'd0);
    chk("rst_pulse", {31'd0, wb.exc_pulse}, 32'd0);

    // 1: add $5 = 7
    drive(mk_ir(5'b00000, 5'b00000), 32'd7, 5'd5, 1'b0, 32'd0);
    step();
    chk("add_we", {31'd0, wb.rf_we}, 32'd1);
    chk("add_reg", {27'd0, wb.rf_wr_reg}, 32'd5);
    chk("add_data", wb.rf_wr_data, 32'd7);
    chk("add_byp_valid", {31'd0, wb.byp_valid}, 32'd1);
    chk("add_byp_rd", {27'd0, wb.byp_rd}, 32'd5);
    chk("add_byp_data", wb.byp_data, 32'd7);

    // 2: lw selects dmem data; sw and rd 0 never write
    drive(mk_ir(5'b01000, 5'd0), 32'h40, 5'd3, 1'b0, 32'hDEAD);
    step();
    chk("lw_we", {31'd0, wb.rf_we}, 32'd1);
    chk("lw_data", wb.rf_wr_data, 32'hDEAD);
    drive(mk_ir(5'b00111, 5'd0), 32'h40, 5'd3, 1'b0, 32'h1234);
    step();
    chk("sw_we", {31'd0, wb.rf_we}, 32'd0);
    drive(mk_ir(5'b00000, 5'b00000), 32'd9, 5'd0, 1'b0, 32'd0);
    step();
    chk("add_r0_we", {31'd0, wb.rf_we}, 32'd0);

    // 3: addi overflow to $r30 code 2, then stall 3 cycles
    drive(mk_ir(5'b00101, 5'd0), 32'd2, 5'd30, 1'b1, 32'd0);
    step();
    chk("addi_exc_pulse", {31'd0, wb.exc_pulse}, 32'd1);
    chk("addi_exc_we", {31'd0, wb.rf_we}, 32'd1);
    chk("addi_exc_data", wb.rf_wr_data, 32'd2);
    wb.stall = 1'b1;
    drive(mk_ir(5'b00000, 5'b00000), 32'd11, 5'd4, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_pulse", {31'd0, wb.exc_pulse}, 32'd0);
      chk("stall_pending", {31'd0, wb.exc_pending}, 32'd1);
      chk("stall_last", {29'd0, wb.exc_last}, 32'd2);
      chk("stall_hold_data", wb.rf_wr_data, 32'd2);
    end
    wb.stall = 1'b0;
    drive(32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    wb.exc_ack = 1'b1;
    step();
    wb.exc_ack = 1'b0;
    chk("ack_clears", {31'd0, wb.exc_pending}, 32'd0);

    // 4: div exception code 5 with ack on its pulse edge
    drive(mk_ir(5'b00000, 5'b00111), 32'd5, 5'd30, 1'b1, 32'd0);
    step();
    chk("div_pulse", {31'd0, wb.exc_pulse}, 32'd1);
    drive(32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    wb.exc_ack = 1'b1;
    step();
    chk("ack_pulse_pending", {31'd0, wb.exc_pending}, 32'd1);
    chk("ack_pulse_last", {29'd0, wb.exc_last}, 32'd5);
    chk("div_pulse_once", {31'd0, wb.exc_pulse}, 32'd0);
    step();
    wb.exc_ack = 1'b0;
    chk("ack_alone", {31'd0, wb.exc_pending}, 32'd0);

    // Malformed exceptions: normal writes, no pulse
    drive(mk_ir(5'b00101, 5'd0), 32'd2, 5'd7, 1'b1, 32'd0);
    step();
    chk("bad_rd_pulse", {31'd0, wb.exc_pulse}, 32'd0);
    chk("bad_rd_data", wb.rf_wr_data, 32'd2);
    drive(mk_ir(5'b00000, 5'b00001), 32'd6, 5'd30, 1'b1, 32'd0);
    step();
    chk("bad_code_pulse", {31'd0, wb.exc_pulse}, 32'd0);
    chk("bad_code_we", {31'd0, wb.rf_we}, 32'd1);

    // 5: setx to r30, then flush beats stall
    drive(mk_ir(5'b10101, 5'd0), 32'h123, 5'd30, 1'b0, 32'd0);
    step();
    chk("setx_we", {31'd0, wb.rf_we}, 32'd1);
    chk("setx_reg", {27'd0, wb.rf_wr_reg}, 32'd30);
    chk("setx_data", wb.rf_wr_data, 32'h123);
    chk("setx_pulse", {31'd0, wb.exc_pulse}, 32'd0);
    drive(mk_ir(5'b00000, 5'b00000), 32'd7, 5'd5, 1'b0, 32'd0);
    wb.flush = 1'b1;
    wb.stall = 1'b1;
    step();
    wb.flush = 1'b0;
    wb.stall = 1'b0;
    chk("flush_ir", wb.mw_ir, 32'd0);
    chk("flush_we", {31'd0, wb.rf_we}, 32'd0);

    // Async reset mid-cycle after a mul exception
    drive(mk_ir(5'b00000, 5'b00110), 32'd4, 5'd30, 1'b1, 32'd0);
    step();
    chk("mul_pulse", {31'd0, wb.exc_pulse}, 32'd1);
    step();
    chk("mul_last", {29'd0, wb.exc_last}, 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pending", {31'd0, wb.exc_pending}, 32'd0);
    chk("arst_last", {29'd0, wb.exc_last}, 32'd0);
    chk("arst_ir", wb.mw_ir, 32'd0);
    chk("arst_we", {31'd0, wb.rf_we}, 32'd0);
    step();
    chk("arst_held_we", {31'd0, wb.rf_we}, 32'd0);
    reset_n = 1'b1;

`ifdef MW_EXC_COUNT_EN
    // 6: four sub exceptions saturate the 2-bit code-3 counter
    drive(mk_ir(5'b00000, 5'b00001), 32'd3, 5'd30, 1'b1, 32'd0);
    step();
    step();
    chk("cnt3_a", {30'd0, exc_cnt[5:4]}, 32'd1);
    step();
    chk("cnt3_b", {30'd0, exc_cnt[5:4]}, 32'd2);
    step();
    chk("cnt3_c", {30'd0, exc_cnt[5:4]}, 32'd3);
    drive(32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    step();
    chk("cnt3_sat", {30'd0, exc_cnt[5:4]}, 32'd3);
    chk("cnt_others", {22'd0, exc_cnt & 10'b11_11_00_11_11}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
